// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-N valid/ready stream demultiplexer.
// Each accepted input beat is steered by in_sel into a one-entry holding
// register for that channel and held until the channel's consumer takes it.
// A stalled consumer only blocks beats addressed to its own channel.
// Beats with in_sel >= N are accepted and discarded.
// Optional feature macro: DMUX_STREAM_DROP_CNT_EN adds an 8-bit saturating
// drop_count output that counts discarded (out-of-range) input transfers.
module dmux_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready
`ifdef DMUX_STREAM_DROP_CNT_EN
    ,
    output logic [7:0]           drop_count
`endif
);

    // Channel count widened by one bit so in_sel can be compared against it
    // even when N is a power of two.
    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic [N*WIDTH-1:0] slot_data_r;
    logic [N-1:0]       slot_valid_r;
    logic [SEL_W:0]     sel_ext_s;
    logic               in_range_s;
    logic               sel_busy_s;
    logic               in_ready_s;
    logic [N-1:0]       load_s;
    logic [N-1:0]       drain_s;

    assign sel_ext_s = {1'b0, in_sel};
    assign out_data  = slot_data_r;
    assign out_valid = slot_valid_r;
    assign in_ready  = in_ready_s;

    // Decode the destination slot and decide whether it can take a beat;
    // out-of-range selects are always ready so they drain without stalling.
    always_comb begin
        in_range_s = (sel_ext_s < N_EXT);
        sel_busy_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel_ext_s == (SEL_W + 1)'(k)) begin
                sel_busy_s = slot_valid_r[k] & ~out_ready[k];
            end else begin
                sel_busy_s = sel_busy_s;
            end
        end
        if (in_range_s) begin
            in_ready_s = ~sel_busy_s;
        end else begin
            in_ready_s = 1'b1;
        end
    end

    // Per-channel load and drain strobes for the slot registers.
    always_comb begin
        load_s  = '0;
        drain_s = '0;
        for (int k = 0; k < N; k++) begin
            if (in_valid && in_ready_s && (sel_ext_s == (SEL_W + 1)'(k))) begin
                load_s[k] = 1'b1;
            end else begin
                load_s[k] = 1'b0;
            end
            drain_s[k] = slot_valid_r[k] & out_ready[k];
        end
    end

    // Slot registers: load wins over drain so a simultaneous load and drain
    // keeps the channel valid with the new beat; data is kept after a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_r <= '0;
            slot_data_r  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load_s[k]) begin
                    slot_data_r[k*WIDTH +: WIDTH] <= in_data;
                    slot_valid_r[k]               <= 1'b1;
                end else if (drain_s[k]) begin
                    slot_valid_r[k]               <= 1'b0;
                end else begin
                    slot_valid_r[k]               <= slot_valid_r[k];
                end
            end
        end
    end

`ifdef DMUX_STREAM_DROP_CNT_EN
    logic [7:0] drop_cnt_r;
    logic       drop_s;

    assign drop_s     = in_valid & in_ready_s & ~in_range_s;
    assign drop_count = drop_cnt_r;

    // Saturating count of discarded out-of-range beats; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_dmux_stream.sv
// Self-checking bench for dmux_stream (WIDTH=8, N=5 so out-of-range selects
// exist). The driver pushes expected beats into per-channel queues; a monitor
// on the falling edge compares every presented beat against the queue front
// and pops it when the consumer accepts.
module tb_dmux_stream;

    localparam int WIDTH = 8;
    localparam int N     = 5;
    localparam int SEL_W = 3;

    logic                 clk;
    logic                 rst;
    logic [WIDTH-1:0]     in_data;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
`ifdef DMUX_STREAM_DROP_CNT_EN
    logic [7:0]           drop_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] exp_q [N][$];

    dmux_stream #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef DMUX_STREAM_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: inputs change just after the rising edge, and
    // in_ready is checked against the hand-computed value at the falling edge.
    task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] d,
                         input logic [N-1:0] rdy, input logic exp_rdy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        if (v && exp_rdy && (int'(s) < N)) begin
            exp_q[int'(s)].push_back(d);
        end
    endtask

    task automatic flush();
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
        end
    endtask

    // Monitor: every presented beat must match the oldest expected beat of
    // its channel (this also checks stability under backpressure).
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < N; k++) begin
                if (out_valid[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        chk("unexpected_valid", {63'd0, out_valid[k]}, 64'd0);
                    end else begin
                        chk("out_data", {56'd0, out_data[k*WIDTH +: WIDTH]}, {56'd0, exp_q[k][0]});
                        if (out_ready[k] === 1'b1) begin
                            void'(exp_q[k].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        in_data   = 8'h55;
        out_ready = 5'b11111;

        // Reset held 3 cycles with a beat presented: nothing may load.
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rst_out_valid", {59'd0, out_valid}, 64'd0);
            chk("rst_out_data", {24'd0, out_data}, 64'd0);
            chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        end
`ifdef DMUX_STREAM_DROP_CNT_EN
        chk("rst_drop_count", {56'd0, drop_count}, 64'd0);
`endif
        rst = 1'b0;
        exp_q[0].push_back(8'h55);
        drive(1'b0, 3'd0, 8'h00, 5'b11111, 1'b1);
        chk("first_after_rst", {59'd0, out_valid}, 64'd1);
        drive(1'b0, 3'd0, 8'h00, 5'b11111, 1'b1);
        chk("drained_after_rst", {59'd0, out_valid}, 64'd0);

        // Basic steering: one beat per channel on consecutive cycles.
        for (int k = 0; k < N; k++) begin
            drive(1'b1, SEL_W'(k), 8'hA0 + 8'(k), 5'b11111, 1'b1);
            if (k > 0) begin
                chk("steer_onehot", {59'd0, out_valid}, 64'(5'b00001 << (k - 1)));
            end
        end
        drive(1'b0, 3'd0, 8'h00, 5'b11111, 1'b1);
        chk("steer_last", {59'd0, out_valid}, 64'(5'b10000));
        drive(1'b0, 3'd0, 8'h00, 5'b11111, 1'b1);
        chk("steer_one_cycle", {59'd0, out_valid}, 64'd0);

        // in_valid low with an in-range select loads nothing.
        drive(1'b0, 3'd3, 8'h99, 5'b11111, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 5'b11111, 1'b1);
        chk("no_load_when_idle", {59'd0, out_valid}, 64'd0);

        // Backpressure isolation on channel 2.
        drive(1'b1, 3'd2, 8'h11, 5'b11011, 1'b1);
        drive(1'b1, 3'd2, 8'h22, 5'b11011, 1'b0);
        drive(1'b1, 3'd1, 8'h33, 5'b11011, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 5'b11011, 1'b1);
        chk("bp_ch1_arrives", {59'd0, out_valid}, 64'(5'b00110));
        drive(1'b0, 3'd2, 8'h00, 5'b11011, 1'b0);
        chk("bp_ch2_hold", {56'd0, out_data[2*WIDTH +: WIDTH]}, 64'h11);
        drive(1'b1, 3'd2, 8'h22, 5'b11111, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 5'b11111, 1'b1);
        chk("bp_second_valid", {59'd0, out_valid}, 64'(5'b00100));
        chk("bp_second_data", {56'd0, out_data[2*WIDTH +: WIDTH]}, 64'h22);

        // Full throughput on channel 0.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'd0, 8'h40 + 8'(i), 5'b11111, 1'b1);
            if (i > 0) begin
                chk("thru_valid", {63'd0, out_valid[0]}, 64'd1);
            end
        end
        drive(1'b0, 3'd1, 8'h00, 5'b11111, 1'b1);
        chk("thru_valid_last", {63'd0, out_valid[0]}, 64'd1);
        drive(1'b0, 3'd1, 8'h00, 5'b11111, 1'b1);
        chk("thru_done", {59'd0, out_valid}, 64'd0);

        // Out-of-range selects: accepted, discarded, counted with saturation.
        drive(1'b0, 3'd7, 8'h00, 5'b11111, 1'b1);
        drive(1'b1, 3'd5, 8'h5A, 5'b11111, 1'b1);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 3'd7, 8'(i), 5'b11111, 1'b1);
`ifdef DMUX_STREAM_DROP_CNT_EN
            if (i == 200) begin
                chk("drop_count_mid", {56'd0, drop_count}, 64'd201);
            end
`endif
        end
        drive(1'b0, 3'd0, 8'h00, 5'b11111, 1'b1);
        chk("drop_no_valid", {59'd0, out_valid}, 64'd0);
`ifdef DMUX_STREAM_DROP_CNT_EN
        chk("drop_count_sat", {56'd0, drop_count}, 64'd255);
`endif

        // Reset mid-stream with channels 0 and 3 stalled and full.
        drive(1'b1, 3'd0, 8'hC0, 5'b10110, 1'b1);
        drive(1'b1, 3'd3, 8'hC3, 5'b10110, 1'b1);
        drive(1'b0, 3'd1, 8'h00, 5'b10110, 1'b1);
        chk("mid_full", {59'd0, out_valid}, 64'(5'b01001));
        drive(1'b0, 3'd0, 8'h00, 5'b10110, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sel   = 3'd1;
        in_data  = 8'hEE;
        flush();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {59'd0, out_valid}, 64'd0);
        chk("mid_rst_data", {24'd0, out_data}, 64'd0);
`ifdef DMUX_STREAM_DROP_CNT_EN
        chk("mid_rst_drop", {56'd0, drop_count}, 64'd0);
`endif
        drive(1'b1, 3'd3, 8'hD3, 5'b11111, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 5'b11111, 1'b1);
        chk("resume_valid", {59'd0, out_valid}, 64'(5'b01000));
        drive(1'b0, 3'd0, 8'h00, 5'b11111, 1'b1);

        for (int k = 0; k < N; k++) begin
            chk("queue_empty", 64'(exp_q[k].size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmux_stream.md
# dmux_stream

Registered 1-to-N stream demultiplexer. It is the parametrised successor of the fixed 1-to-4 combinational demux: it handles arbitrary data width and channel count, uses valid/ready handshaking, and has a one-entry holding register per output channel. Each accepted input beat is steered by `in_sel` into one channel's register and held there until that channel's consumer takes it. It sits between a single producer and N independent consumers; a stalled consumer blocks only beats addressed to that consumer.

## Interface
Parameters:
- `WIDTH`, default 8: data bits per beat.
- `N`, default 4: number of output channels, N ≥ 2. N need not be a power of two.
- `SEL_W`, default `$clog2(N)`: select width. Must equal `$clog2(N)` and must not be overridden.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_data`  in  WIDTH  input beat.
- `in_sel`  in  SEL_W  destination channel of the current input beat.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `out_data`  out  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`  out  N  per-channel beat present.
- `out_ready`  in  N  per-channel consumer accepts.
- `drop_count`  out  8  present only with `DMUX_STREAM_DROP_CNT_EN`; see Configuration.

## Operation
- Per channel k, state is `slot_data[k]` (WIDTH bits) and `slot_valid[k]`. `out_data[k] = slot_data[k]` and `out_valid[k] = slot_valid[k]`, both driven directly from flops.
- Input transfer: occurs when `in_valid & in_ready`.
- `in_ready` is combinational:
  - For `in_sel < N`: `in_ready = ~slot_valid[in_sel] | out_ready[in_sel]`.
  - For `in_sel >= N`: `in_ready = 1`, and the beat is discarded.
- Output transfer on channel k: occurs when `out_valid[k] & out_ready[k]`.
- Slot k update, per cycle:
  - Load if an input transfer occurs with `in_sel == k`: `slot_data[k] <= in_data`, `slot_valid[k] <= 1`.
  - Otherwise, if an output transfer occurs on k: `slot_valid[k] <= 0`. `slot_data[k]` holds its value; it is not cleared.
  - Otherwise: slot k holds.
- Simultaneous load and drain on the same channel is allowed: the old beat leaves, the new beat is loaded, and `out_valid[k]` stays 1. Full rate of one beat per cycle per channel is sustained.
- Loading one channel never affects any other channel. Any number of channels may drain in the same cycle.
- While `out_valid[k]=1` and `out_ready[k]=0`, `out_data[k]` must remain stable.
- `in_valid=0`: no load occurs, whatever `in_sel` is. `in_ready` is still driven by the rule above.
- Ordering: beats addressed to the same channel emerge in acceptance order. No ordering guarantee exists across channels.

## Timing
- Latency: a beat accepted at edge t is visible on `out_valid`/`out_data` in the cycle after edge t (1 cycle).
- Combinational paths: `out_ready → in_ready` and `in_sel → in_ready`. There is no combinational path from any input to `out_valid` or `out_data`.
- Reset (`rst=1` at an edge): all `slot_valid <= 0`, all `slot_data <= 0`, and `drop_count <= 0`.
- During reset: `in_ready` still evaluates its formula. Any beats held in slots are lost. A beat presented in the reset cycle is not loaded.
- First load is possible at the first edge with `rst=0`.
- Reset asserted mid-stream: the channel outputs go 0 on the next cycle regardless of `out_ready`.

## Configuration
- `DMUX_STREAM_DROP_CNT_EN` defined:
  - Adds the `drop_count` port: an 8-bit counter of input transfers with `in_sel >= N`.
  - Increments by 1 per discarded beat and saturates at 255 (no wrap).
  - Cleared only by `rst`.
  - When N is a power of two, the counter stays 0.
- `DMUX_STREAM_DROP_CNT_EN` not defined:
  - No `drop_count` port and no counter logic.
  - Out-of-range beats are still accepted and discarded silently.

## Test plan
- Reset check: hold `rst` 3 cycles while `in_valid=1` → all `out_valid=0` and `out_data=0`; the first output appears 1 cycle after `rst` falls.
- Basic steering: WIDTH=8, N=4, all `out_ready=1`; send 0xA0..0xA3 with sel 0..3 on consecutive cycles → channel k shows 0xAk exactly one cycle after its beat, valid for one cycle.
- Backpressure isolation: `out_ready[2]=0`; send 0x11 to ch2, then 0x22 to ch2, then 0x33 to ch1:
  - `in_ready` drops on the second beat.
  - 0x33 still arrives on ch1.
  - ch2 holds 0x11 stable until `out_ready[2]` rises.
  - 0x22 then follows in the next cycle.
- Full throughput: ch0 valid with `out_ready[0]=1`; stream 16 beats to ch0 back-to-back → `in_ready` stays 1, and `out_valid[0]` stays 1 for 16 consecutive cycles with the data in order.
- Drop and saturation: N=5, macro defined; 300 beats with `in_sel=7` → all accepted, no `out_valid` asserted, `drop_count=255`.
- Reset mid-stream: 2 channels stalled and full; assert `rst` for 1 cycle → all `out_valid=0` next cycle, then normal operation resumes.
